srcnn_sdiv_20s_8s_12_seq: RTL and testbench



---
 rtl/srcnn_sdiv_20s_8s_12_seq_pkg.sv | 34 +++
 rtl/srcnn_sdiv_20s_8s_12_seq_if.sv | 32 +++
 rtl/srcnn_sdiv_20s_8s_12_seq_step.sv | 27 ++
 rtl/srcnn_sdiv_20s_8s_12_seq.sv | 140 ++++++++++++++
 tb/tb_srcnn_sdiv_20s_8s_12_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/srcnn_sdiv_20s_8s_12_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : srcnn_div_pkg
// Brief   : Shared widths, saturation limits, FSM encoding and magnitude
//           helpers for the SRCNN requantisation divider.
// Rev     : 1.0  initial release
// ============================================================================
package srcnn_div_pkg;

    localparam int DIVIDEND_W = 20;
    localparam int DIVISOR_W  = 8;
    localparam int QUOT_W     = 12;
    localparam int QMAX       = 2047;
    localparam int QMIN       = -2048;
    localparam int ITER       = 20;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Magnitudes are kept unsigned, so -2^19 and -128 negate without overflow
    function automatic logic [DIVIDEND_W-1:0] abs_dvd(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? -v : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] abs_dvs(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/srcnn_sdiv_20s_8s_12_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : srcnn_sdiv_20s_8s_12_seq_if
// Brief     : Operand/result valid-ready bundle of the iterative divider.
// Rev       : 1.0  initial release
// ============================================================================
interface srcnn_sdiv_20s_8s_12_seq_if;
    import srcnn_div_pkg::*;

    logic                  in_vld;
    logic                  in_rdy;
    logic [DIVIDEND_W-1:0] din0;
    logic [DIVISOR_W-1:0]  din1;
    logic                  out_vld;
    logic                  out_rdy;
    logic [QUOT_W-1:0]     quot;
    logic [DIVISOR_W-1:0]  rem;
    logic                  ovf;
    logic                  dbz;

    modport slave (
        input  in_vld, din0, din1, out_rdy,
        output in_rdy, out_vld, quot, rem, ovf, dbz
    );

    modport master (
        output in_vld, din0, din1, out_rdy,
        input  in_rdy, out_vld, quot, rem, ovf, dbz
    );

endinterface
`default_nettype wire

// File: rtl/srcnn_sdiv_20s_8s_12_seq_step.sv
`default_nettype none
// ============================================================================
// Module : srcnn_udiv_step
// Brief  : One combinational restoring-division step on unsigned magnitudes.
// Rev    : 1.0  initial release
// ============================================================================
module srcnn_udiv_step
    import srcnn_div_pkg::*;
#(
    parameter int W = DIVISOR_W
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] w_shift;

    assign w_shift = {rem_i, bit_i};
    assign q_o     = (w_shift >= {1'b0, div_i});
    // Either result is below the divisor (<= 2^(W-1)), so W bits always hold it
    assign rem_o   = q_o ? W'(w_shift - {1'b0, div_i}) : w_shift[W-1:0];

endmodule
`default_nettype wire

// File: rtl/srcnn_sdiv_20s_8s_12_seq.sv
`default_nettype none
// ============================================================================
// Module : srcnn_sdiv_20s_8s_12_seq
// Brief  : 20s / 8s iterative signed divider, 12-bit saturated quotient,
//          fixed 20-cycle latency, valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
module srcnn_sdiv_20s_8s_12_seq
    import srcnn_div_pkg::*;
(
    input  logic                              ap_clk,
    input  logic                              ap_rst,
    srcnn_sdiv_20s_8s_12_seq_if.slave         bus
);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W-1:0]  prem_q;
    logic                  sgn0_q;
    logic                  sgn1_q;
    logic                  zdiv_q;

    logic                  in_rdy_q;
    logic                  out_vld_q;
    logic [QUOT_W-1:0]     quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic                  ovf_q;
    logic                  dbz_q;

    logic [DIVISOR_W-1:0]  w_prem_d;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_qmag;
    logic [QUOT_W-1:0]     quot_d;
    logic [DIVISOR_W-1:0]  rem_d;
    logic                  ovf_d;

    srcnn_udiv_step #(.W(DIVISOR_W)) u_step (
        .rem_i (prem_q),
        .bit_i (dvd_q[DIVIDEND_W-1]),
        .div_i (dvs_q),
        .rem_o (w_prem_d),
        .q_o   (w_qbit)
    );

    // Dividend register doubles as the quotient shift register
    assign w_qmag = {dvd_q[DIVIDEND_W-2:0], w_qbit};

    always_comb begin
        quot_d = '0;
        rem_d  = '0;
        ovf_d  = 1'b0;
        if (zdiv_q) begin
            quot_d = sgn0_q ? QUOT_W'(QMIN) : QUOT_W'(QMAX);
        end else begin
            rem_d = sgn0_q ? -w_prem_d : w_prem_d;
            if (sgn0_q ^ sgn1_q) begin
                if (w_qmag > DIVIDEND_W'(-QMIN)) begin
                    quot_d = QUOT_W'(QMIN);
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = -w_qmag[QUOT_W-1:0];
                end
            end else if (w_qmag > DIVIDEND_W'(QMAX)) begin
                quot_d = QUOT_W'(QMAX);
                ovf_d  = 1'b1;
            end else begin
                quot_d = w_qmag[QUOT_W-1:0];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            sgn0_q    <= 1'b0;
            sgn1_q    <= 1'b0;
            zdiv_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_vld && in_rdy_q) begin
                        dvd_q    <= abs_dvd(bus.din0);
                        dvs_q    <= abs_dvs(bus.din1);
                        sgn0_q   <= bus.din0[DIVIDEND_W-1];
                        sgn1_q   <= bus.din1[DIVISOR_W-1];
                        zdiv_q   <= (bus.din1 == '0);
                        prem_q   <= '0;
                        cnt_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    prem_q <= w_prem_d;
                    dvd_q  <= w_qmag;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        quot_q    <= quot_d;
                        rem_q     <= rem_d;
                        ovf_q     <= ovf_d;
                        dbz_q     <= zdiv_q;
                        out_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_vld = out_vld_q;
    assign bus.quot    = quot_q;
    assign bus.rem     = rem_q;
    assign bus.ovf     = ovf_q;
    assign bus.dbz     = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_srcnn_sdiv_20s_8s_12_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_srcnn_sdiv_20s_8s_12_seq
// Brief  : Directed self-checking bench for the iterative signed divider.
// Rev    : 1.0  initial release
// ============================================================================
module tb_srcnn_sdiv_20s_8s_12_seq;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    srcnn_sdiv_20s_8s_12_seq_if bus ();

    srcnn_sdiv_20s_8s_12_seq dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input int a, input int b);
        int g;
        g = 0;
        @(negedge clk);
        while (bus.in_rdy !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        bus.din0   = 20'(a);
        bus.din1   = 8'(b);
        bus.in_vld = 1'b1;
        @(posedge clk);
        #1 bus.in_vld = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_vld !== 1'b1 && lat < 40);
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1 bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.in_rdy, bus.out_vld, bus.quot, bus.rem, bus.ovf, bus.dbz} !== {1'b1, 1'b0, 12'd0, 8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset got rdy=%b vld=%b quot=%0d rem=%0d ovf=%b dbz=%b want rdy=1 vld=0 zeros",
                     bus.in_rdy, bus.out_vld, bus.quot, bus.rem, bus.ovf, bus.dbz);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        int a  [12] = '{1000, -1000, 1000, -1000, 100000, -524288, 524287, -16384, 16376, 16384, -16392, 0};
        int b  [12] = '{7, 7, -7, -7, 3, -128, -128, 8, 8, 8, 8, 5};
        int eq [12] = '{142, -142, -142, 142, 2047, 2047, -2048, -2048, 2047, 2047, -2048, 0};
        int er [12] = '{6, -6, 6, -6, 1, 0, 127, 0, 0, 0, 0, 0};
        bit eo [12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
        int lat;
        for (int i = 0; i < 12; i++) begin
            start_op(a[i], b[i]);
            wait_result(lat);
            n_vec++;
            if (lat !== 20) begin
                n_err++;
                $display("FAIL arith_latency[%0d] got %0d cycles want 20", i, lat);
            end
            n_vec++;
            if ({bus.quot, bus.rem, bus.ovf, bus.dbz} !== {12'(eq[i]), 8'(er[i]), eo[i], 1'b0}) begin
                n_err++;
                $display("FAIL arith[%0d] %0d/%0d got quot=%0d rem=%0d ovf=%b dbz=%b want quot=%0d rem=%0d ovf=%b dbz=0",
                         i, a[i], b[i], $signed(bus.quot), $signed(bus.rem), bus.ovf, bus.dbz, eq[i], er[i], eo[i]);
            end
            release_result();
        end
    endtask

    task automatic test_div_by_zero();
        int a  [4] = '{500, -500, 0, -524288};
        int eq [4] = '{2047, -2048, 2047, -2048};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(a[i], 0);
            wait_result(lat);
            n_vec++;
            if (lat !== 20) begin
                n_err++;
                $display("FAIL dbz_latency[%0d] got %0d cycles want 20", i, lat);
            end
            n_vec++;
            if ({bus.quot, bus.rem, bus.ovf, bus.dbz} !== {12'(eq[i]), 8'd0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL dbz[%0d] %0d/0 got quot=%0d rem=%0d ovf=%b dbz=%b want quot=%0d rem=0 ovf=0 dbz=1",
                         i, a[i], $signed(bus.quot), $signed(bus.rem), bus.ovf, bus.dbz, eq[i]);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(1000, 7);
        wait_result(lat);
        n_vec++;
        if (lat !== 20) begin
            n_err++;
            $display("FAIL bp_latency got %0d cycles want 20", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.din0   = 20'($urandom);
            bus.din1   = 8'($urandom);
            bus.in_vld = ~bus.in_vld;
            @(posedge clk);
            #1;
            n_vec++;
            if ({bus.out_vld, bus.in_rdy, bus.quot, bus.rem, bus.ovf, bus.dbz} !== {1'b1, 1'b0, 12'd142, 8'd6, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got vld=%b rdy=%b quot=%0d rem=%0d ovf=%b dbz=%b want vld=1 rdy=0 quot=142 rem=6 ovf=0 dbz=0",
                         c, bus.out_vld, bus.in_rdy, $signed(bus.quot), $signed(bus.rem), bus.ovf, bus.dbz);
            end
        end
        @(negedge clk);
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1 bus.out_rdy = 1'b0;
        n_vec++;
        if ({bus.out_vld, bus.in_rdy} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", bus.out_vld, bus.in_rdy);
        end
        start_op(-7, 2);
        wait_result(lat);
        n_vec++;
        if (lat !== 20) begin
            n_err++;
            $display("FAIL bp_next_latency got %0d cycles want 20", lat);
        end
        n_vec++;
        if ({bus.quot, bus.rem, bus.ovf, bus.dbz} !== {-12'sd3, -8'sd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL bp_next got quot=%0d rem=%0d ovf=%b dbz=%b want quot=-3 rem=-1 ovf=0 dbz=0",
                     $signed(bus.quot), $signed(bus.rem), bus.ovf, bus.dbz);
        end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        start_op(1000, 7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.out_vld, bus.in_rdy, bus.quot, bus.rem, bus.ovf, bus.dbz} !== {1'b0, 1'b1, 12'd0, 8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midrst got vld=%b rdy=%b quot=%0d rem=%0d ovf=%b dbz=%b want vld=0 rdy=1 zeros",
                     bus.out_vld, bus.in_rdy, $signed(bus.quot), $signed(bus.rem), bus.ovf, bus.dbz);
        end
        rst = 1'b0;
        start_op(1000, 7);
        wait_result(lat);
        n_vec++;
        if (lat !== 20) begin
            n_err++;
            $display("FAIL midrst_latency got %0d cycles want 20", lat);
        end
        n_vec++;
        if ({bus.quot, bus.rem, bus.ovf, bus.dbz} !== {12'd142, 8'd6, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_result got quot=%0d rem=%0d ovf=%b dbz=%b want quot=142 rem=6 ovf=0 dbz=0",
                     $signed(bus.quot), $signed(bus.rem), bus.ovf, bus.dbz);
        end
        release_result();
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        bus.din0    = '0;
        bus.din1    = '0;
        test_reset();
        test_arith();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
